// File: rtl/writeback_arbiter.sv
// Writeback stage: arbitrates buffered ALU results against unbuffered load returns
// onto the register-file write port, and tracks registers with loads in flight.
module writeback_arbiter #(
  parameter int XLEN           = 32,
  parameter int REG_ID_W       = 5,
  parameter int ALU_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              alu_valid,
  output logic                              alu_ready,
  input  logic [REG_ID_W-1:0]               alu_rd,
  input  logic [XLEN-1:0]                   alu_data,
  input  logic                              mem_valid,
  output logic                              mem_ready,
  input  logic [REG_ID_W-1:0]               mem_rd,
  input  logic [XLEN-1:0]                   mem_data,
  input  logic                              issue_mark,
  input  logic [REG_ID_W-1:0]               issue_rd,
  input  logic [REG_ID_W-1:0]               rs1_id,
  input  logic [REG_ID_W-1:0]               rs2_id,
  output logic                              rs1_busy,
  output logic                              rs2_busy,
  output logic                              wb_enable,
  output logic [REG_ID_W-1:0]               wb_id,
  output logic [XLEN-1:0]                   wb_data,
  output logic [$clog2(ALU_FIFO_DEPTH):0]   fifo_count
);

  localparam int AW    = $clog2(ALU_FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int NREGS = 1 << REG_ID_W;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [REG_ID_W-1:0] rd;
    logic [XLEN-1:0]     data;
  } wb_req_t;

  wb_req_t          fifo_mem [ALU_FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve_cnt;
  logic [NREGS-1:0] busy, set_mask, clr_mask;

  logic    fifo_empty, fifo_full, forced, mem_win, fifo_pop, push, win_vld;
  wb_req_t head, win;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(ALU_FIFO_DEPTH));
  assign head       = fifo_mem[rd_ptr];

  // Memory normally has priority; a starved, non-empty FIFO takes one slot back.
  assign forced   = !fifo_empty && (starve_cnt == SW'(STARVE_LIMIT));
  assign mem_win  = mem_valid && !forced;
  assign fifo_pop = !fifo_empty && !mem_win;
  assign win_vld  = mem_win || fifo_pop;
  assign win      = mem_win ? wb_req_t'{rd: mem_rd, data: mem_data} : head;

  assign mem_ready = !forced;
  assign alu_ready = !fifo_full || fifo_pop;
  assign push      = alu_valid && alu_ready;

  assign fifo_count = count;

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wb_req_t'{rd: alu_rd, data: alu_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + AW'(1);
      if (fifo_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, fifo_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                          starve_cnt <= '0;
    else if (fifo_empty || fifo_pop)  starve_cnt <= '0;
    else if (mem_win && starve_cnt != SW'(STARVE_LIMIT))
                                      starve_cnt <= starve_cnt + SW'(1);
  end

  // x0 winners still complete their handshake but never write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_enable <= 1'b0;
      wb_id     <= '0;
      wb_data   <= '0;
    end else begin
      wb_enable <= win_vld && (win.rd != '0);
      wb_id     <= win.rd;
      wb_data   <= win.data;
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_mark)             set_mask[issue_rd] = 1'b1;
    if (mem_valid && mem_ready) clr_mask[mem_rd]   = 1'b1;
    set_mask[0] = 1'b0;
  end

  // Set is applied after clear so a same-cycle reissue keeps the register busy.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= (busy & ~clr_mask) | set_mask;
  end

  assign rs1_busy = busy[rs1_id];
  assign rs2_busy = busy[rs2_id];

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: per-cycle vector table plus starvation and reset sequences;
// every register-file write is matched against an expected-write queue.
module tb_writeback_arbiter;

  logic        clk, rst;
  logic        alu_valid, alu_ready, mem_valid, mem_ready, issue_mark;
  logic [4:0]  alu_rd, mem_rd, issue_rd, rs1_id, rs2_id, wb_id;
  logic [31:0] alu_data, mem_data, wb_data;
  logic        rs1_busy, rs2_busy, wb_enable;
  logic [1:0]  fifo_count;

  writeback_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_mark(issue_mark), .issue_rd(issue_rd),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wb_enable(wb_enable), .wb_id(wb_id), .wb_data(wb_data), .fifo_count(fifo_count)
  );

  typedef struct {
    logic [4:0]  id;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        alu_v; logic [4:0] alu_rd; logic [31:0] alu_d;
    logic        mem_v; logic [4:0] mem_rd; logic [31:0] mem_d;
    logic        iss;   logic [4:0] iss_rd;
    logic [4:0]  rs1;   logic [4:0] rs2;
    logic        e_ar;  logic e_mr; logic e_b1; logic e_b2; logic [1:0] e_fc;
    logic        push;  logic [4:0] p_id; logic [31:0] p_d;
  } vec_t;

  wr_t  exp_q[$];
  vec_t tbl[13];
  int   errors = 0;
  int   checks = 0;
  int   mi;

  bit       er_mem[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  bit       er_alu[10] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  bit [1:0] er_fc[10]  = '{1, 2, 2, 2, 2, 2, 2, 2, 2, 2};

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    issue_mark = 0; issue_rd = 0; rs1_id = 0; rs2_id = 0;
  endtask

  task automatic push_exp(input logic [4:0] id, input logic [31:0] d);
    wr_t w;
    w.id = id; w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic apply(input vec_t v, input int idx);
    alu_valid = v.alu_v; alu_rd = v.alu_rd; alu_data = v.alu_d;
    mem_valid = v.mem_v; mem_rd = v.mem_rd; mem_data = v.mem_d;
    issue_mark = v.iss; issue_rd = v.iss_rd; rs1_id = v.rs1; rs2_id = v.rs2;
    @(negedge clk);
    chk($sformatf("vec%0d alu_ready", idx), {31'd0, alu_ready}, {31'd0, v.e_ar});
    chk($sformatf("vec%0d mem_ready", idx), {31'd0, mem_ready}, {31'd0, v.e_mr});
    chk($sformatf("vec%0d rs1_busy", idx), {31'd0, rs1_busy}, {31'd0, v.e_b1});
    chk($sformatf("vec%0d rs2_busy", idx), {31'd0, rs2_busy}, {31'd0, v.e_b2});
    chk($sformatf("vec%0d fifo_count", idx), {30'd0, fifo_count}, {30'd0, v.e_fc});
    if (v.push) push_exp(v.p_id, v.p_d);
    @(posedge clk); #1;
  endtask

  initial begin
    // Writeback monitor: each enabled write must be the next expected one.
    fork
      forever begin
        @(negedge clk);
        if (wb_enable === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL wb_unexpected: got id=%0d data=%h expected no write at %0t",
                     wb_id, wb_data, $time);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wb_id", {27'd0, wb_id}, {27'd0, e.id});
            chk("wb_data", wb_data, e.data);
          end
        end
      end
      begin
        #100000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog");
      end
    join_none

    //            alu_v rd  data          mem_v rd  data            iss rd  rs1 rs2  ar mr b1 b2 fc  push id data
    tbl[0]  = '{1'b1, 5'd5, 32'hAA,       1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd5, 1, 1, 0, 0, 2'd0, 1'b1, 5'd5,  32'hAA};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  5'd0, 1, 1, 0, 0, 2'd1, 1'b0, 5'd0,  32'h0};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd7, 1, 1, 1, 1, 2'd0, 1'b0, 5'd0,  32'h0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd0, 1, 1, 1, 0, 2'd0, 1'b0, 5'd0,  32'h0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd0,  5'd7,  5'd0, 1, 1, 1, 0, 2'd0, 1'b1, 5'd7,  32'hDEADBEEF};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd0, 1, 1, 0, 0, 2'd0, 1'b0, 5'd0,  32'h0};
    tbl[6]  = '{1'b1, 5'd0, 32'h11,       1'b1, 5'd0,  32'h22,       1'b0, 5'd0,  5'd0,  5'd0, 1, 1, 0, 0, 2'd0, 1'b0, 5'd0,  32'h0};
    tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd0, 1, 1, 0, 0, 2'd1, 1'b0, 5'd0,  32'h0};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd0, 1, 1, 0, 0, 2'd0, 1'b0, 5'd0,  32'h0};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd12, 32'h1234,     1'b1, 5'd12, 5'd12, 5'd0, 1, 1, 0, 0, 2'd0, 1'b1, 5'd12, 32'h1234};
    tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd12, 5'd7, 1, 1, 1, 0, 2'd0, 1'b0, 5'd0,  32'h0};
    tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd12, 32'h5678,     1'b0, 5'd0,  5'd12, 5'd0, 1, 1, 1, 0, 2'd0, 1'b1, 5'd12, 32'h5678};
    tbl[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd12, 5'd0, 1, 1, 0, 0, 2'd0, 1'b0, 5'd0,  32'h0};

    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset wb_enable", {31'd0, wb_enable}, 32'd0);
    chk("reset wb_id", {27'd0, wb_id}, 32'd0);
    chk("reset wb_data", wb_data, 32'd0);
    chk("reset fifo_count", {30'd0, fifo_count}, 32'd0);
    chk("reset alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("reset mem_ready", {31'd0, mem_ready}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      rs1_id = 5'(i);
      rs2_id = 5'(31 - i);
      @(negedge clk);
      chk($sformatf("reset rs1_busy[%0d]", i), {31'd0, rs1_busy}, 32'd0);
      chk($sformatf("reset rs2_busy[%0d]", 31 - i), {31'd0, rs2_busy}, 32'd0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) apply(tbl[i], i);
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;

    // Starvation: rd3/rd4 wait behind a stream of loads; rd10 enqueues while full and popping.
    for (int i = 0; i < 4; i++) push_exp(5'd9, 32'hC0DE0000 + 32'(i));
    push_exp(5'd3, 32'h33);
    for (int i = 4; i < 8; i++) push_exp(5'd9, 32'hC0DE0000 + 32'(i));
    push_exp(5'd4, 32'h44);
    push_exp(5'd10, 32'hA0);

    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h33;
    @(negedge clk);
    chk("starve pre fifo_count", {30'd0, fifo_count}, 32'd0);
    @(posedge clk); #1;
    mi = 0;
    for (int j = 0; j < 10; j++) begin
      alu_valid = (j == 0) || (j == 4);
      alu_rd    = (j == 0) ? 5'd4 : 5'd10;
      alu_data  = (j == 0) ? 32'h44 : 32'hA0;
      mem_valid = 1; mem_rd = 5'd9; mem_data = 32'hC0DE0000 + 32'(mi);
      @(negedge clk);
      chk($sformatf("starve%0d mem_ready", j), {31'd0, mem_ready}, {31'd0, er_mem[j]});
      chk($sformatf("starve%0d alu_ready", j), {31'd0, alu_ready}, {31'd0, er_alu[j]});
      chk($sformatf("starve%0d fifo_count", j), {30'd0, fifo_count}, {30'd0, er_fc[j]});
      if (er_mem[j]) mi++;
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    chk("starve drain1 fifo_count", {30'd0, fifo_count}, 32'd1);
    chk("starve drain1 mem_ready", {31'd0, mem_ready}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("starve drain2 fifo_count", {30'd0, fifo_count}, 32'd0);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;

    // Reset with a full FIFO and pending busy bits.
    alu_valid = 1; alu_rd = 5'd6; alu_data = 32'h66;
    mem_valid = 1; mem_rd = 5'd9; mem_data = 32'h99;
    issue_mark = 1; issue_rd = 5'd20;
    @(negedge clk);
    chk("rst_seq p fifo_count", {30'd0, fifo_count}, 32'd0);
    push_exp(5'd9, 32'h99);
    @(posedge clk); #1;
    alu_rd = 5'd8; alu_data = 32'h88; mem_data = 32'h9A; issue_rd = 5'd21;
    @(negedge clk);
    chk("rst_seq q alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("rst_seq q mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("rst_seq q fifo_count", {30'd0, fifo_count}, 32'd1);
    push_exp(5'd9, 32'h9A);
    @(posedge clk); #1;
    idle_inputs();
    rs1_id = 5'd20; rs2_id = 5'd21;
    rst = 1;
    @(negedge clk);
    chk("rst_seq r fifo_count", {30'd0, fifo_count}, 32'd2);
    chk("rst_seq r rs1_busy", {31'd0, rs1_busy}, 32'd1);
    chk("rst_seq r rs2_busy", {31'd0, rs2_busy}, 32'd1);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_seq s fifo_count", {30'd0, fifo_count}, 32'd0);
    chk("rst_seq s wb_enable", {31'd0, wb_enable}, 32'd0);
    chk("rst_seq s rs1_busy", {31'd0, rs1_busy}, 32'd0);
    chk("rst_seq s rs2_busy", {31'd0, rs2_busy}, 32'd0);
    chk("rst_seq s alu_ready", {31'd0, alu_ready}, 32'd1);
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    chk("final fifo_count", {30'd0, fifo_count}, 32'd0);
    chk("pending writes", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writeback stage sitting directly upstream of the architectural register file; drives its write port (enable/id/data), one write per cycle.
- Merges two result sources: single-cycle ALU results, buffered in a small FIFO, and load results returned by the memory unit.
- Holds a per-register busy scoreboard for outstanding loads so decode can stall on RAW hazards against in-flight loads.

Parameters:
- XLEN, 32, data width of results and register-file write data (matches op_t).
- REG_ID_W, 5, register index width (matches reg_id_t).
- ALU_FIFO_DEPTH, 2, ALU result FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 4, consecutive cycles a non-empty ALU FIFO may lose to memory before it is forced to win.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid && alu_ready.
- alu_rd  in  REG_ID_W  ALU destination register.
- alu_data  in  XLEN  ALU result.
- mem_valid  in  1  load result offered.
- mem_ready  out  1  load result accepted when mem_valid && mem_ready.
- mem_rd  in  REG_ID_W  load destination register.
- mem_data  in  XLEN  load data.
- issue_mark  in  1  a load is issued; mark issue_rd busy.
- issue_rd  in  REG_ID_W  destination of the issued load.
- rs1_id  in  REG_ID_W  decode source 1 query.
- rs2_id  in  REG_ID_W  decode source 2 query.
- rs1_busy  out  1  rs1_id has a load outstanding.
- rs2_busy  out  1  rs2_id has a load outstanding.
- wb_enable  out  1  register-file write enable.
- wb_id  out  REG_ID_W  register-file write index.
- wb_data  out  XLEN  register-file write data.
- fifo_count  out  clog2(ALU_FIFO_DEPTH)+1  ALU FIFO occupancy.

Behaviour:
- Reset (rst=1 at a clk edge): FIFO empty, fifo_count=0, busy vector all 0, starve counter 0, wb_enable=0, wb_id=0, wb_data=0. Reset mid-operation discards FIFO contents and pending busy bits, and no write is issued in the following cycle.
- wb_enable, wb_id and wb_data are registered; the register file captures them on the next edge.
- ALU path: an accepted ALU result is enqueued at the edge. It is eligible for selection from the next cycle.
  - Minimum latency: accept in cycle N, wb_enable high in cycle N+2.
- alu_ready = !full || fifo_pop_this_cycle, where pop is the FIFO head winning arbitration.
- Mem path is not buffered: accepted in cycle N, wb_enable high in cycle N+1.
- Arbitration each cycle, one winner:
  - Mem wins if mem_valid, unless starve_cnt == STARVE_LIMIT and the FIFO is non-empty; in that case the FIFO head wins.
  - Otherwise the FIFO head wins if the FIFO is non-empty.
  - mem_ready = !(FIFO forced win).
- Starve counter:
  - Increments when the FIFO is non-empty and mem wins.
  - Resets to 0 when the FIFO head wins or the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Register x0: a winner with rd==0 completes its handshake and pops normally, but the registered output is wb_enable=0 (wb_id/wb_data don't-care). No winner means wb_enable=0 next cycle.
- Simultaneous enqueue and pop when full is allowed; occupancy stays unchanged. FIFO pointers wrap modulo ALU_FIFO_DEPTH.
- Scoreboard, 32 bits:
  - issue_mark sets busy[issue_rd] at the edge; issue_rd==0 is ignored.
  - An accepted mem result clears busy[mem_rd] at the edge.
  - Set and clear of the same register in the same cycle: set wins.
  - rsN_busy = busy[rsN_id] combinational; always 0 for index 0.
  - A cleared register reads not-busy in the same cycle its wb_enable is asserted. The register file holds the value from the following edge; decode is responsible for forwarding or a one-cycle bubble.
- Ordering: no ordering is enforced between ALU and mem results to the same rd. Issue logic must not allow an ALU write to a busy rd.

Test Plan:
- Reset, then idle -> wb_enable=0, alu_ready=1, mem_ready=1, fifo_count=0, rs1_busy=0 for all ids.
- ALU accepts rd=5, data=0x0000_00AA in cycle 1, with no mem traffic -> wb_enable=1, wb_id=5, wb_data=0xAA in cycle 3; fifo_count is 1 in cycle 2 and 0 in cycle 3.
- Load path: issue_mark rd=7 in cycle 1, so rs1_id=7 gives rs1_busy=1 from cycle 2. Mem returns rd=7, data=0xDEAD_BEEF in cycle 4 -> wb in cycle 5 with wb_id=7 and wb_data=0xDEADBEEF; rs1_busy=0 from cycle 5.
- ALU rd=3 and rd=4 queued; mem_valid held high for 8 cycles with rd=9 and varying data -> after 4 mem wins, mem_ready=0 for one cycle and rd=3 is written; then 4 more mem wins, then rd=4. alu_ready=0 while fifo_count=2 and no pop occurs.
- Writes to rd=0 from both ALU and mem -> handshakes complete, wb_enable stays 0; issue_mark rd=0 leaves rs1_busy=0.
- issue_mark rd=12 in the same cycle mem returns rd=12 -> busy[12] remains 1. Asserting rst while fifo_count=2 -> next cycle fifo_count=0, wb_enable=0, all busy=0.
